// File: rtl/dvi_tmds_encoder_if.sv
// Pixel-side bus of the TMDS encoder: video/control inputs and the encoded symbol.
// With TMDS_TERC4_EN defined the bus also carries the data-island controls island/terc.
interface dvi_tmds_encoder_if;
    logic              de;
    logic [7:0]        din;
    logic [1:0]        ctrl;
    logic [9:0]        dout;
    logic signed [4:0] disparity;
`ifdef TMDS_TERC4_EN
    logic              island;
    logic [3:0]        terc;

    modport master (output de, din, ctrl, island, terc, input dout, disparity);
    modport slave  (input de, din, ctrl, island, terc, output dout, disparity);
`else
    modport master (output de, din, ctrl, input dout, disparity);
    modport slave  (input de, din, ctrl, output dout, disparity);
`endif
endinterface

// File: rtl/dvi_tmds_encoder.sv
// Single-channel DVI TMDS 8b/10b encoder, fixed two-stage pipeline in the pixel-clock domain.
// Optional macro TMDS_TERC4_EN adds TERC4 data-island symbols with priority island > de > control.
module dvi_tmds_encoder #(
    parameter logic [9:0] CTRL_RESET = 10'h354
) (
    input  logic              clk,
    input  logic              resetn,
    dvi_tmds_encoder_if.slave bus
);

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
        return n;
    endfunction

    function automatic logic [9:0] ctrlToken(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = 10'b1101010100;
            2'b01:   t = 10'b0010101011;
            2'b10:   t = 10'b0101010100;
            default: t = 10'b1010101011;
        endcase
        return t;
    endfunction

`ifdef TMDS_TERC4_EN
    function automatic logic [9:0] terc4Token(input logic [3:0] t);
        logic [9:0] s;
        case (t)
            4'd0:    s = 10'b1010011100;
            4'd1:    s = 10'b1001100011;
            4'd2:    s = 10'b1011100100;
            4'd3:    s = 10'b1011100010;
            4'd4:    s = 10'b0101110001;
            4'd5:    s = 10'b0100011110;
            4'd6:    s = 10'b0110001110;
            4'd7:    s = 10'b0100111100;
            4'd8:    s = 10'b1011001100;
            4'd9:    s = 10'b0100111001;
            4'd10:   s = 10'b0110011100;
            4'd11:   s = 10'b1011000110;
            4'd12:   s = 10'b1010001110;
            4'd13:   s = 10'b1001110001;
            4'd14:   s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction
`endif

    // Stage 1: transition-minimised word q_m; XNOR chain chosen when din is ones-heavy
    logic [3:0] n1d;
    logic       useXnor;
    logic [8:0] qm_d;

    always_comb begin
        n1d     = popcount8(bus.din);
        useXnor = (n1d > 4'd4) || ((n1d == 4'd4) && !bus.din[0]);
        qm_d    = '0;
        qm_d[0] = bus.din[0];
        for (int i = 1; i < 8; i++)
            qm_d[i] = useXnor ? ~(qm_d[i-1] ^ bus.din[i]) : (qm_d[i-1] ^ bus.din[i]);
        qm_d[8] = ~useXnor;
    end

    logic       de_q;
    logic [1:0] ctrl_q;
    logic [8:0] qm_q;
`ifdef TMDS_TERC4_EN
    logic       island_q;
    logic [3:0] terc_q;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            de_q     <= 1'b0;
            ctrl_q   <= 2'b00;
            qm_q     <= '0;
`ifdef TMDS_TERC4_EN
            island_q <= 1'b0;
            terc_q   <= 4'd0;
`endif
        end else begin
            de_q     <= bus.de;
            ctrl_q   <= bus.ctrl;
            qm_q     <= qm_d;
`ifdef TMDS_TERC4_EN
            island_q <= bus.island;
            terc_q   <= bus.terc;
`endif
        end
    end

    // Stage 2: pick polarity of q_m against the running disparity; diff = n1q - n0q
    logic [3:0]        n1q;
    logic signed [4:0] diff;
    logic signed [4:0] cnt_d;
    logic signed [4:0] cnt_q;
    logic [9:0]        dout_d;
    logic [9:0]        dout_q;
    logic              forceCtrl;

    always_comb begin
        n1q    = popcount8(qm_q[7:0]);
        diff   = $signed({n1q, 1'b0} - 5'd8);
        dout_d = ctrlToken(ctrl_q);
        cnt_d  = 5'sd0;
        forceCtrl = !de_q;
`ifdef TMDS_TERC4_EN
        if (island_q) begin
            dout_d    = terc4Token(terc_q);
            forceCtrl = 1'b0;
        end else
`endif
        if (forceCtrl) begin
            dout_d = ctrlToken(ctrl_q);
        end else if ((cnt_q == 5'sd0) || (n1q == 4'd4)) begin
            dout_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            cnt_d  = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
        end else if (((cnt_q > 5'sd0) && (n1q > 4'd4)) || ((cnt_q < 5'sd0) && (n1q < 4'd4))) begin
            dout_d = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_d  = cnt_q + (qm_q[8] ? 5'sd2 : 5'sd0) - diff;
        end else begin
            dout_d = {1'b0, qm_q[8], qm_q[7:0]};
            cnt_d  = cnt_q + diff - (qm_q[8] ? 5'sd0 : 5'sd2);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout_q <= CTRL_RESET;
            cnt_q  <= 5'sd0;
        end else begin
            dout_q <= dout_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.disparity = cnt_q;

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Directed-vector bench for dvi_tmds_encoder, plus a reference-model random DC-balance run.
// Define TMDS_TERC4_EN for both RTL and bench to exercise the TERC4 data-island path.
module tb_dvi_tmds_encoder;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   testsRun = 0;
    int   testsFailed = 0;
    int   modelCnt = 0;

    dvi_tmds_encoder_if bus ();

    dvi_tmds_encoder #(.CTRL_RESET(10'h354)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic de, input logic [7:0] din, input logic [1:0] ctrl);
        bus.de   = de;
        bus.din  = din;
        bus.ctrl = ctrl;
`ifdef TMDS_TERC4_EN
        bus.island = 1'b0;
        bus.terc   = 4'd0;
`endif
    endtask

    // Straight reading of the DVI encoding rules, with integer disparity bookkeeping
    function automatic logic [9:0] modelEncode(input logic [7:0] d);
        logic [8:0] qm;
        logic [9:0] sym;
        int n1d, n1, n0, q8;
        n1d = $countones(d);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) qm[i] = ~(qm[i-1] ^ d[i]);
            else                                        qm[i] = qm[i-1] ^ d[i];
        end
        qm[8] = (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) ? 1'b0 : 1'b1;
        q8 = qm[8] ? 1 : 0;
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (modelCnt == 0 || n1 == n0) begin
            sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            modelCnt = modelCnt + (q8 == 1 ? (n1 - n0) : (n0 - n1));
        end else if ((modelCnt > 0 && n1 > n0) || (modelCnt < 0 && n0 > n1)) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            modelCnt = modelCnt + 2 * q8 + (n0 - n1);
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            modelCnt = modelCnt + (n1 - n0) - 2 * (1 - q8);
        end
        return sym;
    endfunction

    task automatic test_reset();
        int act;
        resetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
            step();
            act = bus.disparity;
            testsRun++;
            if (bus.dout !== 10'h354 || act !== 0) begin
                testsFailed++;
                $display("[TB] FAIL reset_hold: dout=%h disp=%0d expected 354/0", bus.dout, act);
            end
        end
        applyStimulus(1'b0, 8'h00, 2'b01);
        resetn = 1'b1;
        step();
        testsRun++;
        if (bus.dout !== 10'h354) begin
            testsFailed++;
            $display("[TB] FAIL reset_release_first: dout=%h expected 354", bus.dout);
        end
        step();
        testsRun++;
        if (bus.dout !== 10'h0AB) begin
            testsFailed++;
            $display("[TB] FAIL reset_release_second: dout=%h expected 0ab", bus.dout);
        end
    endtask

    task automatic test_control_tokens();
        logic [9:0] tok [4];
        int act;
        tok[0] = 10'h354; tok[1] = 10'h0AB; tok[2] = 10'h154; tok[3] = 10'h2AB;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 8'hA5, 2'(i % 4));
            step();
            if (i > 0) begin
                act = bus.disparity;
                testsRun++;
                if (bus.dout !== tok[i-1] || act !== 0) begin
                    testsFailed++;
                    $display("[TB] FAIL ctrl_token%0d: dout=%h disp=%0d expected %h/0", i - 1, bus.dout, act, tok[i-1]);
                end
            end
        end
    endtask

    task automatic test_zero_pixels();
        int act;
        applyStimulus(1'b0, 8'h00, 2'b00);
        step();
        applyStimulus(1'b1, 8'h00, 2'b00);
        step();
        applyStimulus(1'b1, 8'h00, 2'b00);
        step();
        act = bus.disparity;
        testsRun++;
        if (bus.dout !== 10'h100 || act !== -8) begin
            testsFailed++;
            $display("[TB] FAIL zero_pixel1: dout=%h disp=%0d expected 100/-8", bus.dout, act);
        end
        applyStimulus(1'b0, 8'h00, 2'b00);
        step();
        act = bus.disparity;
        testsRun++;
        if (bus.dout !== 10'h3FF || act !== 2) begin
            testsFailed++;
            $display("[TB] FAIL zero_pixel2: dout=%h disp=%0d expected 3ff/2", bus.dout, act);
        end
        step();
        act = bus.disparity;
        testsRun++;
        if (bus.dout !== 10'h354 || act !== 0) begin
            testsFailed++;
            $display("[TB] FAIL zero_pixel_ctrl: dout=%h disp=%0d expected 354/0", bus.dout, act);
        end
    endtask

    task automatic test_full_pixel();
        int act;
        applyStimulus(1'b0, 8'h00, 2'b00);
        step();
        applyStimulus(1'b1, 8'hFF, 2'b00);
        step();
        applyStimulus(1'b0, 8'h00, 2'b00);
        step();
        act = bus.disparity;
        testsRun++;
        if (bus.dout !== 10'h200 || act !== -8) begin
            testsFailed++;
            $display("[TB] FAIL full_pixel: dout=%h disp=%0d expected 200/-8", bus.dout, act);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic       vDe   [5];
        logic [7:0] vDin  [5];
        logic [1:0] vCtrl [5];
        logic [9:0] eSym  [5];
        int         eDisp [5];
        int act;
        vDe[0] = 0; vDin[0] = 8'h00; vCtrl[0] = 1; eSym[0] = 10'h0AB; eDisp[0] = 0;
        vDe[1] = 1; vDin[1] = 8'h00; vCtrl[1] = 0; eSym[1] = 10'h100; eDisp[1] = -8;
        vDe[2] = 0; vDin[2] = 8'h00; vCtrl[2] = 2; eSym[2] = 10'h154; eDisp[2] = 0;
        vDe[3] = 1; vDin[3] = 8'hFF; vCtrl[3] = 0; eSym[3] = 10'h200; eDisp[3] = -8;
        vDe[4] = 0; vDin[4] = 8'h00; vCtrl[4] = 3; eSym[4] = 10'h2AB; eDisp[4] = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) applyStimulus(vDe[i], vDin[i], vCtrl[i]);
            else       applyStimulus(1'b0, 8'h00, 2'b00);
            step();
            if (i > 0) begin
                act = bus.disparity;
                testsRun++;
                if (bus.dout !== eSym[i-1] || act !== eDisp[i-1]) begin
                    testsFailed++;
                    $display("[TB] FAIL toggle_de%0d: dout=%h disp=%0d expected %h/%0d", i - 1, bus.dout, act, eSym[i-1], eDisp[i-1]);
                end
            end
        end
    endtask

    task automatic test_dc_balance();
        logic [7:0] d;
        logic [9:0] expSym, prevSym;
        int expDisp, prevDisp, act, cumBal;
        applyStimulus(1'b0, 8'h00, 2'b00);
        step();
        step();
        modelCnt = 0;
        cumBal = 0;
        prevSym = '0;
        prevDisp = 0;
        for (int i = 0; i <= 10000; i++) begin
            if (i < 10000) begin
                d = 8'($urandom_range(0, 255));
                applyStimulus(1'b1, d, 2'b00);
                expSym = modelEncode(d);
                expDisp = modelCnt;
            end else begin
                applyStimulus(1'b0, 8'h00, 2'b00);
            end
            step();
            if (i > 0) begin
                act = bus.disparity;
                cumBal = cumBal + 2 * $countones(bus.dout) - 10;
                testsRun++;
                if (bus.dout !== prevSym || act !== prevDisp) begin
                    testsFailed++;
                    $display("[TB] FAIL dc_model[%0d]: dout=%h disp=%0d expected %h/%0d", i - 1, bus.dout, act, prevSym, prevDisp);
                end
                testsRun++;
                if (act > 10 || act < -10 || cumBal > 19 || cumBal < -19) begin
                    testsFailed++;
                    $display("[TB] FAIL dc_bound[%0d]: disp=%0d cumulative=%0d limits 10/19", i - 1, act, cumBal);
                end
            end
            prevSym = expSym;
            prevDisp = expDisp;
        end
    endtask

    task automatic test_reset_midstream();
        int act;
        applyStimulus(1'b1, 8'h00, 2'b00);
        step();
        step();
        #2;
        resetn = 1'b0;
        #1;
        act = bus.disparity;
        testsRun++;
        if (bus.dout !== 10'h354 || act !== 0) begin
            testsFailed++;
            $display("[TB] FAIL reset_async: dout=%h disp=%0d expected 354/0", bus.dout, act);
        end
        step();
        applyStimulus(1'b1, 8'hFF, 2'b00);
        resetn = 1'b1;
        step();
        act = bus.disparity;
        testsRun++;
        if (bus.dout !== 10'h354 || act !== 0) begin
            testsFailed++;
            $display("[TB] FAIL reset_flush: dout=%h disp=%0d expected 354/0", bus.dout, act);
        end
        applyStimulus(1'b0, 8'h00, 2'b00);
        step();
        step();
    endtask

`ifdef TMDS_TERC4_EN
    function automatic logic [9:0] terc4Ref(input int t);
        logic [9:0] tbl [16];
        tbl = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
        return tbl[t];
    endfunction

    task automatic test_terc4();
        int act;
        for (int t = 0; t < 17; t++) begin
            applyStimulus(1'b0, 8'h00, 2'b00);
            if (t < 16) begin
                bus.island = 1'b1;
                bus.terc   = 4'(t);
            end else begin
                bus.de     = 1'b1;
                bus.din    = 8'hFF;
                bus.island = 1'b1;
                bus.terc   = 4'd5;
            end
            step();
            if (t > 0) begin
                act = bus.disparity;
                testsRun++;
                if (bus.dout !== terc4Ref(t - 1) || act !== 0) begin
                    testsFailed++;
                    $display("[TB] FAIL terc4_%0d: dout=%b disp=%0d expected %b/0", t - 1, bus.dout, act, terc4Ref(t - 1));
                end
            end
        end
        applyStimulus(1'b0, 8'h00, 2'b00);
        step();
        act = bus.disparity;
        testsRun++;
        if (bus.dout !== terc4Ref(5) || act !== 0) begin
            testsFailed++;
            $display("[TB] FAIL terc4_over_de: dout=%b disp=%0d expected %b/0", bus.dout, act, terc4Ref(5));
        end
    endtask
`endif

    initial begin
        test_reset();
        test_control_tokens();
        test_zero_pixels();
        test_full_pixel();
        test_back_to_back();
        test_dc_balance();
        test_reset_midstream();
`ifdef TMDS_TERC4_EN
        test_terc4();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
